// File: rtl/switch_debounce_pkg.sv
// Types shared by the switch debouncer; the state values come from switch_defs.v.
package switch_debounce_pkg;
`include "switch_defs.v"

  typedef enum logic [1:0] {
    ST_LOW       = S_LOW,
    ST_RISE_WAIT = S_RISE_WAIT,
    ST_HIGH      = S_HIGH,
    ST_FALL_WAIT = S_FALL_WAIT
  } state_t;
endpackage

// File: rtl/switch_debounce_sync2.sv
// Two-flop synchronizer bringing the raw switch level into the clk domain.
module sync2 (
  input  logic clk,
  input  logic i_aclr,
  input  logic i_a,
  output logic o_y
);
  logic meta;

  // Metastability stage followed by the clean output stage.
  always_ff @(posedge clk or posedge i_aclr) begin
    if (i_aclr) begin
      meta <= 1'b0;
      o_y  <= 1'b0;
    end else begin
      meta <= i_a;
      o_y  <= meta;
    end
  end
endmodule

// File: rtl/switch_defs.v
// Shared FSM state encoding for the switch debouncer.
`ifndef SWITCH_DEFS_V
`define SWITCH_DEFS_V
localparam logic [1:0] S_LOW       = 2'd0;
localparam logic [1:0] S_RISE_WAIT = 2'd1;
localparam logic [1:0] S_HIGH      = 2'd2;
localparam logic [1:0] S_FALL_WAIT = 2'd3;
`endif

// File: rtl/switch_debounce.sv
// Switch debouncer: synchronizes i_sw, then requires STABLE_TICKS consecutive
// i_tick samples of a new level before committing it.
// Optional: define SWITCH_DEBOUNCE_RELEASE_PULSE_EN to enable the o_release pulse;
// otherwise o_release is tied low.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int                  CNT_WIDTH    = 4,
  parameter logic [CNT_WIDTH-1:0] STABLE_TICKS = 4'd10
) (
  input  logic clk,
  input  logic i_aclr,
  input  logic i_tick,
  input  logic i_sw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LAST = STABLE_TICKS - ONE;

  logic                 w_sw;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 press_q, press_d;
`ifdef SWITCH_DEBOUNCE_RELEASE_PULSE_EN
  logic                 release_q, release_d;
`endif

  sync2 u_sync (
    .clk    (clk),
    .i_aclr (i_aclr),
    .i_a    (i_sw),
    .o_y    (w_sw)
  );

  // Next state, counter and commit pulses; a reverting level beats a committing tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
`ifdef SWITCH_DEBOUNCE_RELEASE_PULSE_EN
    release_d = 1'b0;
`endif
    unique case (state_q)
      ST_LOW: begin
        if (w_sw) begin
          state_d = ST_RISE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RISE_WAIT: begin
        if (!w_sw) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (i_tick) begin
          if (cnt_q == LAST) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      ST_HIGH: begin
        if (!w_sw) begin
          state_d = ST_FALL_WAIT;
          cnt_d   = '0;
        end
      end
      ST_FALL_WAIT: begin
        if (w_sw) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (i_tick) begin
          if (cnt_q == LAST) begin
            state_d = ST_LOW;
            cnt_d   = '0;
`ifdef SWITCH_DEBOUNCE_RELEASE_PULSE_EN
            release_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and press pulse registers.
  always_ff @(posedge clk or posedge i_aclr) begin
    if (i_aclr) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

`ifdef SWITCH_DEBOUNCE_RELEASE_PULSE_EN
  // Release pulse register, present only when the pulse is enabled.
  always_ff @(posedge clk or posedge i_aclr) begin
    if (i_aclr) release_q <= 1'b0;
    else        release_q <= release_d;
  end
  assign o_release = release_q;
`else
  assign o_release = 1'b0;
`endif

  // The committed level is held through the opposite wait state.
  assign o_level = (state_q == ST_HIGH) || (state_q == ST_FALL_WAIT);
  assign o_press = press_q;
endmodule
